// File: rtl/cory_fifo_tpram_ctrl.sv
// rtl/cory_fifo_tpram_ctrl.sv - FIFO controller for a two-port RAM with registered read.
// A 2-entry output buffer absorbs the RAM read latency so both sides run at one word per clock.
module cory_fifo_tpram_ctrl #(
  parameter int A     = 8,
  parameter int D     = 8,
  parameter int DEPTH = 2**A
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           i_valid,
  input  logic [D-1:0]   i_data,
  output logic           i_ready,
  output logic           o_valid,
  output logic [D-1:0]   o_data,
  input  logic           o_ready,
  output logic [A+1:0]   level,
  output logic           ram_wen,
  output logic [A-1:0]   ram_waddr,
  output logic [D-1:0]   ram_wdata,
  output logic           ram_ren,
  output logic [A-1:0]   ram_raddr,
  input  logic [D-1:0]   ram_rdata
);

  localparam logic [A:0]   DEPTH_N = (A+1)'(DEPTH);
  localparam logic [A-1:0] LAST    = (A)'(DEPTH - 1);

  logic [A-1:0] wptr, rptr;
  logic [A:0]   ram_cnt, ram_cnt_nx;
  logic         rd_pend;
  logic [D-1:0] obuf0, obuf1;
  logic [1:0]   ob_cnt, ob_after_pop, ob_cnt_nx;
  logic         wr, pop, rd_issue;

  function automatic logic [A-1:0] adv(input logic [A-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign i_ready = !reset && (ram_cnt < DEPTH_N);
  assign wr      = i_valid & i_ready;
  assign o_valid = (ob_cnt != 2'd0);
  assign o_data  = obuf0;
  assign pop     = o_valid & o_ready;

  // A read may issue only if its word will have a free buffer slot when it lands.
  always_comb begin
    ob_after_pop = ob_cnt - {1'b0, pop};
    ob_cnt_nx    = ob_after_pop + {1'b0, rd_pend};
    rd_issue     = !reset && (ram_cnt != '0) && (ob_cnt_nx < 2'd2);
    ram_cnt_nx   = ram_cnt + (A+1)'(wr) - (A+1)'(rd_issue);
  end

  assign ram_wen   = !wr;
  assign ram_waddr = wptr;
  assign ram_wdata = i_data;
  assign ram_ren   = !rd_issue;
  assign ram_raddr = rptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr    <= '0;
      rptr    <= '0;
      ram_cnt <= '0;
      rd_pend <= 1'b0;
      ob_cnt  <= 2'd0;
      level   <= '0;
    end else begin
      if (wr)       wptr <= adv(wptr);
      if (rd_issue) rptr <= adv(rptr);
      ram_cnt <= ram_cnt_nx;
      rd_pend <= rd_issue;
      ob_cnt  <= ob_cnt_nx;
      level   <= (A+2)'(ram_cnt_nx) + (A+2)'(rd_issue) + (A+2)'(ob_cnt_nx);
    end
  end

  // Capture overrides the shift when the landing slot is the head.
  always_ff @(posedge clk) begin
    if (pop) obuf0 <= obuf1;
    if (rd_pend && !reset) begin
      if (ob_after_pop == 2'd0) obuf0 <= ram_rdata;
      else                      obuf1 <= ram_rdata;
    end
  end

`ifdef SIM
  initial begin
    if (DEPTH < 2 || DEPTH > 2**A) begin
      $display("ERROR: cory_fifo_tpram_ctrl DEPTH=%0d outside 2..%0d", DEPTH, 2**A);
      $finish;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) assert (ob_cnt_nx != 2'd3) else $error("output buffer overflow");
  end
`endif

endmodule

// File: tb/tb_cory_fifo_tpram_ctrl.sv
// tb/tb_cory_fifo_tpram_ctrl.sv - self-checking bench for cory_fifo_tpram_ctrl.
// Queue-based model with word ages predicts every output; directed scenarios pin literal values.
module tb_cory_fifo_tpram_ctrl;
  localparam int A = 2;
  localparam int D = 8;
  localparam int DEPTH = 3;

  logic clk = 1'b0;
  logic reset, i_valid, i_ready, o_valid, o_ready;
  logic [D-1:0] i_data, o_data, ram_wdata, ram_rdata;
  logic [A+1:0] level;
  logic ram_wen, ram_ren;
  logic [A-1:0] ram_waddr, ram_raddr;

  always #5 clk = ~clk;

  cory_fifo_tpram_ctrl #(.A(A), .D(D), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .i_valid(i_valid), .i_data(i_data), .i_ready(i_ready),
    .o_valid(o_valid), .o_data(o_data), .o_ready(o_ready), .level(level),
    .ram_wen(ram_wen), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .ram_ren(ram_ren), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata)
  );

  logic [D-1:0] mem [2**A];
  always @(posedge clk) begin
    if (!ram_wen) mem[ram_waddr] <= ram_wdata;
    if (!ram_ren) ram_rdata <= mem[ram_raddr];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: FIFO contents tagged with the edge at which each word was accepted.
  typedef struct { logic [D-1:0] d; int t; } ent_t;
  ent_t q[$];
  int cyc = 0;
  int wcount = 0;
  int rcount = 0;
  bit chk_en = 0;

  // Words already pulled out of RAM: up to 2, each at least one edge old.
  function automatic int out_stage();
    int n = 0;
    foreach (q[i]) if (q[i].t <= cyc - 1) n++;
    return (n > 2) ? 2 : n;
  endfunction

  function automatic bit exp_i_ready();
    return !reset && ((q.size() - out_stage()) < DEPTH);
  endfunction

  function automatic bit exp_o_valid();
    return (q.size() > 0) && (q[0].t <= cyc - 2);
  endfunction

  always @(posedge clk) begin
    bit w, p, r;
    ent_t e;
    w = i_valid && exp_i_ready();
    p = exp_o_valid() && o_ready;
    r = !ram_ren;
    cyc = cyc + 1;
    if (reset) begin
      q.delete();
      wcount = 0;
      rcount = 0;
    end else begin
      if (p) void'(q.pop_front());
      if (w) begin
        e.d = i_data;
        e.t = cyc;
        q.push_back(e);
        wcount++;
      end
      if (r) rcount++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("i_ready", i_ready, exp_i_ready());
      chk("o_valid", o_valid, exp_o_valid());
      if (exp_o_valid()) chk("o_data", o_data, q[0].d);
      chk("level", level, q.size());
      chk("ram_wen", ram_wen, !(i_valid && exp_i_ready()));
      if (!ram_wen) begin
        chk("ram_waddr", ram_waddr, wcount % DEPTH);
        chk("ram_wdata", ram_wdata, i_data);
      end
      if (!ram_ren) chk("ram_raddr", ram_raddr, rcount % DEPTH);
      if (!ram_wen && !ram_ren) chk("addr_hazard", ram_waddr != ram_raddr, 1);
    end
  end

  logic [D-1:0] got[$];
  int gotc[$];
  int maxlev = 0;
  always @(negedge clk) begin
    if (chk_en) begin
      if (o_valid && o_ready) begin
        got.push_back(o_data);
        gotc.push_back(cyc);
      end
      if (int'(level) > maxlev) maxlev = int'(level);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    i_valid = 1'b0;
    o_ready = 1'b0;
    tick();
    chk_en = 1;
    @(negedge clk);
    chk("rst_o_valid", o_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_ram_wen", ram_wen, 1);
    chk("rst_ram_ren", ram_ren, 1);
    chk("rst_i_ready", i_ready, 0);
    #1 reset = 1'b0;
  endtask

  initial begin
    logic [D-1:0] sent[$];
    int acc, bad;
    reset = 1'b1; i_valid = 1'b0; i_data = '0; o_ready = 1'b0;

    // Single word latency
    do_reset();
    o_ready = 1'b1; i_valid = 1'b1; i_data = 8'hA5;
    #1;
    chk("lat_wen", ram_wen, 0);
    chk("lat_waddr", ram_waddr, 0);
    tick();
    i_valid = 1'b0;
    @(negedge clk);
    chk("lat_ren", ram_ren, 0);
    chk("lat_raddr", ram_raddr, 0);
    chk("lat_level1", level, 1);
    tick();
    @(negedge clk);
    chk("lat_level2", level, 1);
    chk("lat_ovalid_early", o_valid, 0);
    tick();
    @(negedge clk);
    chk("lat_ovalid", o_valid, 1);
    chk("lat_odata", o_data, 8'hA5);
    chk("lat_level3", level, 1);
    tick();
    @(negedge clk);
    chk("lat_level4", level, 0);

    // Fill to capacity with the consumer stalled, then drain
    do_reset();
    got.delete(); gotc.delete();
    acc = 0;
    for (int k = 0; k < 10; k++) begin
      i_valid = 1'b1; i_data = D'(k);
      #1;
      chk("full_iready", i_ready, (k < 5) ? 1 : 0);
      if (i_ready) acc++;
      tick();
    end
    i_valid = 1'b0;
    chk("full_accept", acc, 5);
    tick();
    @(negedge clk);
    chk("full_level", level, 5);
    chk("full_ren", ram_ren, 1);
    tick();
    o_ready = 1'b1;
    @(negedge clk);
    chk("full_iready_prepop", i_ready, 0);
    tick();
    @(negedge clk);
    chk("full_iready_reopen", i_ready, 1);
    for (int k = 0; k < 12; k++) tick();
    chk("full_count", got.size(), 5);
    for (int k = 0; k < got.size(); k++) chk("full_order", got[k], k);

    // Continuous streaming
    do_reset();
    got.delete(); gotc.delete();
    maxlev = 0;
    o_ready = 1'b1;
    for (int k = 0; k < 100; k++) begin
      i_valid = 1'b1; i_data = D'(k);
      tick();
    end
    i_valid = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    chk("stream_count", got.size(), 100);
    bad = 0;
    for (int k = 0; k < got.size(); k++)
      if (got[k] !== D'(k) || gotc[k] != gotc[0] + k) bad++;
    chk("stream_order_rate", bad, 0);
    chk("stream_maxlevel", maxlev <= 3, 1);

    // Random traffic
    do_reset();
    got.delete(); gotc.delete(); sent.delete();
    acc = 0;
    for (int c = 0; c < 20000 && acc < 1000; c++) begin
      i_valid = $urandom_range(0, 1);
      i_data = D'($urandom);
      o_ready = (c % 4 == 0) || (c % 4 == 3);
      #1;
      if (i_valid && i_ready) begin
        acc++;
        sent.push_back(i_data);
      end
      tick();
    end
    i_valid = 1'b0;
    o_ready = 1'b1;
    for (int c = 0; c < 20; c++) tick();
    chk("rand_accepted", acc, 1000);
    chk("rand_count", got.size(), sent.size());
    bad = 0;
    for (int k = 0; k < got.size() && k < sent.size(); k++) if (got[k] !== sent[k]) bad++;
    chk("rand_order", bad, 0);

    // Reset while a read is in flight
    do_reset();
    for (int k = 0; k < 6; k++) begin
      i_valid = 1'b1; i_data = D'(8'h10 + k);
      tick();
    end
    i_valid = 1'b0;
    @(negedge clk);
    chk("mid_level_full", level, 5);
    tick();
    o_ready = 1'b1;
    tick();
    o_ready = 1'b0;
    @(negedge clk);
    chk("mid_level_prerst", level, 4);
    do_reset();
    got.delete(); gotc.delete();
    i_valid = 1'b1; i_data = 8'h3C; o_ready = 1'b1;
    #1;
    chk("mid_wen", ram_wen, 0);
    chk("mid_waddr", ram_waddr, 0);
    tick();
    i_valid = 1'b0;
    for (int k = 0; k < 8; k++) tick();
    chk("mid_count", got.size(), 1);
    if (got.size() > 0) chk("mid_data", got[0], 8'h3C);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
